// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Register-match rule lives here so slot and top agree on it.
package hazard_pkg;

  localparam int LAT_W_DEF = 5;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } bank_e;

  // Same index and bank; integer x0 is hardwired and never matches.
  function automatic logic reg_match(
    input logic [REG_IDX_W-1:0] idx_a,
    input logic                 fp_a,
    input logic [REG_IDX_W-1:0] idx_b,
    input logic                 fp_b
  );
    return (idx_a == idx_b) && (fp_a == fp_b) &&
           (fp_a || (idx_a != '0));
  endfunction

endpackage

// File: rtl/mc_slot.sv
// One in-flight multi-cycle FPU result: dest, bank, countdown.
// Reports completion, register matches and writeback collisions.
module mc_slot
  import hazard_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEF,
  parameter int NQ    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          load_i,
  input  logic [REG_IDX_W-1:0]          rd_i,
  input  logic                          fp_i,
  input  logic [LAT_W-1:0]              cnt_i,
  input  logic [NQ-1:0][REG_IDX_W-1:0]  q_idx_i,
  input  logic [NQ-1:0]                 q_fp_i,
  input  logic [LAT_W:0]                coll_cnt_i,
  output logic                          valid_o,
  output logic [REG_IDX_W-1:0]          rd_o,
  output logic                          fp_o,
  output logic                          done_o,
  output logic [NQ-1:0]                 match_o,
  output logic                          coll_o
);

  logic                 valid_q, valid_d;
  logic [REG_IDX_W-1:0] rd_q, rd_d;
  logic                 fp_q, fp_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;

  // Allocate, count down, and free after the cnt==1 cycle.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    fp_d    = fp_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      valid_d = 1'b1;
      rd_d    = rd_i;
      fp_d    = fp_i;
      cnt_d   = cnt_i;
    end else if (valid_q) begin
      if (cnt_q == LAT_W'(1)) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      fp_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      fp_q    <= fp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign fp_o    = fp_q;
  assign done_o  = valid_q && (cnt_q == LAT_W'(1));
  assign coll_o  = valid_q && ({1'b0, cnt_q} == coll_cnt_i);

  for (genvar i = 0; i < NQ; i++) begin : g_match
    assign match_o[i] = valid_q &&
      reg_match(q_idx_i[i], q_fp_i[i], rd_q, fp_q);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard scoreboard: load-use and multi-cycle FPU tracking,
// stall generation and serialized multi-cycle writeback strobes.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MC_SLOTS = 2,
  parameter int LAT_W    = LAT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rs3,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic                 id_rs3_used,
  input  logic                 id_rs1_fp,
  input  logic                 id_rs2_fp,
  input  logic                 id_rs3_fp,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_rd_fp,
  input  logic                 id_rd_we,
  input  logic                 id_is_load,
  input  logic                 id_is_mc,
  input  logic [LAT_W-1:0]     id_mc_lat,
  input  logic                 pipe_hold,
  input  logic                 flush,
  output logic                 stall_o,
  output logic                 mc_done_o,
  output logic [REG_IDX_W-1:0] mc_rd_o,
  output logic                 mc_rd_fp_o,
  output logic                 mc_busy_o
);

  localparam int NQ = 4;

  logic [NQ-1:0][REG_IDX_W-1:0] q_idx;
  logic [NQ-1:0]                q_fp;
  logic [2:0]                   src_used;
  logic [LAT_W-1:0]             lat_eff;
  logic [LAT_W:0]               coll_cnt;
  logic                         issue;

  logic [MC_SLOTS-1:0]                s_valid;
  logic [MC_SLOTS-1:0]                s_done;
  logic [MC_SLOTS-1:0]                s_coll;
  logic [MC_SLOTS-1:0]                s_alloc;
  logic [MC_SLOTS-1:0][NQ-1:0]        s_match;
  logic [MC_SLOTS-1:0][REG_IDX_W-1:0] s_rd;
  logic [MC_SLOTS-1:0]                s_fp;

  logic                 ld_v_q, ld_v_d;
  logic [REG_IDX_W-1:0] ld_rd_q, ld_rd_d;
  logic                 ld_fp_q, ld_fp_d;

  logic ld_hit, mc_raw, mc_waw, mc_full, mc_coll;

  assign q_idx    = {id_rd, id_rs3, id_rs2, id_rs1};
  assign q_fp     = {id_rd_fp, id_rs3_fp, id_rs2_fp, id_rs1_fp};
  assign src_used = {id_rs3_used, id_rs2_used, id_rs1_used};
  assign lat_eff  = (id_mc_lat == '0) ? LAT_W'(1) : id_mc_lat;
  assign coll_cnt = {1'b0, lat_eff} + (LAT_W+1)'(1);
  assign issue    = id_valid && !stall_o && !pipe_hold && !flush;

  for (genvar s = 0; s < MC_SLOTS; s++) begin : g_slot
    mc_slot #(
      .LAT_W (LAT_W),
      .NQ    (NQ)
    ) u_slot (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (s_alloc[s]),
      .rd_i       (id_rd),
      .fp_i       (id_rd_fp),
      .cnt_i      (lat_eff),
      .q_idx_i    (q_idx),
      .q_fp_i     (q_fp),
      .coll_cnt_i (coll_cnt),
      .valid_o    (s_valid[s]),
      .rd_o       (s_rd[s]),
      .fp_o       (s_fp[s]),
      .done_o     (s_done[s]),
      .match_o    (s_match[s]),
      .coll_o     (s_coll[s])
    );
  end

  // Lowest-index free slot takes a newly issued multi-cycle op.
  always_comb begin
    logic found;
    s_alloc = '0;
    found   = 1'b0;
    for (int s = 0; s < MC_SLOTS; s++) begin
      if (!s_valid[s] && !found) begin
        s_alloc[s] = issue && id_is_mc;
        found      = 1'b1;
      end
    end
  end

  // Hazard detection against the load tracker and all slots.
  always_comb begin
    ld_hit = 1'b0;
    mc_raw = 1'b0;
    mc_waw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_hit = ld_hit || (ld_v_q && src_used[i] &&
        reg_match(q_idx[i], q_fp[i], ld_rd_q, ld_fp_q));
    end
    for (int s = 0; s < MC_SLOTS; s++) begin
      mc_raw = mc_raw || |(s_match[s][2:0] & src_used);
      mc_waw = mc_waw || (s_match[s][3] && id_rd_we);
    end
  end

  assign mc_full = id_is_mc && (&s_valid);
  assign mc_coll = id_is_mc && (|s_coll);
  assign stall_o = id_valid && !flush &&
    (ld_hit || mc_raw || mc_waw || mc_full || mc_coll);

  // Completion strobe; the lowest completing slot wins.
  always_comb begin
    logic found;
    mc_rd_o    = '0;
    mc_rd_fp_o = 1'b0;
    found      = 1'b0;
    for (int s = 0; s < MC_SLOTS; s++) begin
      if (s_done[s] && !found) begin
        mc_rd_o    = s_rd[s];
        mc_rd_fp_o = s_fp[s];
        found      = 1'b1;
      end
    end
  end

  assign mc_done_o = |s_done;
  assign mc_busy_o = |s_valid;

  // Load tracker next state: hold, capture, or drop to a bubble.
  always_comb begin
    ld_v_d  = 1'b0;
    ld_rd_d = ld_rd_q;
    ld_fp_d = ld_fp_q;
    if (pipe_hold) begin
      ld_v_d = ld_v_q;
    end else if (issue && id_is_load && id_rd_we &&
                 (id_rd_fp || (id_rd != '0))) begin
      ld_v_d  = 1'b1;
      ld_rd_d = id_rd;
      ld_fp_d = id_rd_fp;
    end
  end

  // Load tracker register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ld_v_q  <= 1'b0;
      ld_rd_q <= '0;
      ld_fp_q <= 1'b0;
    end else begin
      ld_v_q  <= ld_v_d;
      ld_rd_q <= ld_rd_d;
      ld_fp_q <= ld_fp_d;
    end
  end

  // Collision avoidance must keep completions one per cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert ($onehot0(s_done));
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazards plus random traffic
// against a cycle-numbered model of in-flight results.
module tb_hazard_scoreboard;

  localparam int MC = 2;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rs3;
  logic       id_rs1_used, id_rs2_used, id_rs3_used;
  logic       id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic [4:0] id_rd;
  logic       id_rd_fp, id_rd_we, id_is_load, id_is_mc;
  logic [4:0] id_mc_lat;
  logic       pipe_hold, flush;
  logic       stall_o, mc_done_o, mc_rd_fp_o, mc_busy_o;
  logic [4:0] mc_rd_o;

  hazard_scoreboard #(.MC_SLOTS(MC), .LAT_W(5)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs3      (id_rs3),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rs3_used (id_rs3_used),
    .id_rs1_fp   (id_rs1_fp),
    .id_rs2_fp   (id_rs2_fp),
    .id_rs3_fp   (id_rs3_fp),
    .id_rd       (id_rd),
    .id_rd_fp    (id_rd_fp),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .id_is_mc    (id_is_mc),
    .id_mc_lat   (id_mc_lat),
    .pipe_hold   (pipe_hold),
    .flush       (flush),
    .stall_o     (stall_o),
    .mc_done_o   (mc_done_o),
    .mc_rd_o     (mc_rd_o),
    .mc_rd_fp_o  (mc_rd_fp_o),
    .mc_busy_o   (mc_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [4:0] rd;
    logic       fp;
    int         done_at;
  } op_t;

  op_t        ops[$];
  bit         ld_v = 0;
  logic [4:0] ld_rd = '0;
  logic       ld_fp = 1'b0;
  int         cyc = 0;
  bit         stall_seen, done_seen;

  function automatic bit m(logic [4:0] a, logic fa, logic [4:0] b,
                           logic fb);
    return (a == b) && (fa == fb) && (fa || a != 0);
  endfunction

  task automatic nop();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0;
    id_rs1_used = 0; id_rs2_used = 0; id_rs3_used = 0;
    id_rs1_fp = 0; id_rs2_fp = 0; id_rs3_fp = 0;
    id_rd = 0; id_rd_fp = 0; id_rd_we = 0;
    id_is_load = 0; id_is_mc = 0; id_mc_lat = 0;
    pipe_hold = 0; flush = 0;
  endtask

  task automatic mc_op(logic [4:0] rd, logic [4:0] lat);
    nop();
    id_valid = 1; id_is_mc = 1; id_rd_we = 1;
    id_rd = rd; id_rd_fp = 1; id_mc_lat = lat;
  endtask

  // One cycle: check outputs mid-cycle, then advance the model.
  task automatic step();
    logic [4:0] si[3];
    logic       sf[3];
    bit         su[3];
    bit         es, ed, iss;
    logic [4:0] erd;
    logic       efp;
    int         le;
    @(negedge clk_i);
    si = '{id_rs1, id_rs2, id_rs3};
    sf = '{id_rs1_fp, id_rs2_fp, id_rs3_fp};
    su = '{id_rs1_used, id_rs2_used, id_rs3_used};
    le = (id_mc_lat == 0) ? 1 : int'(id_mc_lat);
    es = 0;
    for (int k = 0; k < 3; k++)
      if (ld_v && su[k] && m(si[k], sf[k], ld_rd, ld_fp)) es = 1;
    foreach (ops[i]) begin
      for (int k = 0; k < 3; k++)
        if (su[k] && m(si[k], sf[k], ops[i].rd, ops[i].fp)) es = 1;
      if (id_rd_we && m(id_rd, id_rd_fp, ops[i].rd, ops[i].fp)) es = 1;
      if (id_is_mc && ops[i].done_at == cyc + le) es = 1;
    end
    if (id_is_mc && ops.size() >= MC) es = 1;
    if (!id_valid || flush) es = 0;
    ed = 0; erd = 0; efp = 0;
    foreach (ops[i])
      if (ops[i].done_at == cyc && !ed) begin
        ed = 1; erd = ops[i].rd; efp = ops[i].fp;
      end
    chk("stall", stall_o, es);
    chk("done", mc_done_o, ed);
    chk("done_rd", mc_rd_o, erd);
    chk("done_fp", mc_rd_fp_o, efp);
    chk("busy", mc_busy_o, ops.size() != 0);
    stall_seen = stall_o;
    done_seen  = mc_done_o;
    iss = id_valid && !es && !pipe_hold && !flush;
    @(posedge clk_i);
    if (!pipe_hold) begin
      ld_v = iss && id_is_load && id_rd_we && (id_rd_fp || id_rd != 0);
      if (ld_v) begin ld_rd = id_rd; ld_fp = id_rd_fp; end
    end
    if (iss && id_is_mc) ops.push_back('{id_rd, id_rd_fp, cyc + le});
    cyc++;
    for (int i = ops.size() - 1; i >= 0; i--)
      if (ops[i].done_at < cyc) ops.delete(i);
    #1;
  endtask

  // Step until the ID instruction stops stalling; returns stall count.
  task automatic run_stalled(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!stall_seen) return;
      n++;
    end
    chk("stall_timeout", 1, 0);
  endtask

  int n, t0, dcyc, dn;

  initial begin
    nop();
    reset_i = 1;
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_done", mc_done_o, 0);
    chk("rst_busy", mc_busy_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 0;

    // load x5 then reader of x5
    nop(); id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd = 5;
    step();
    nop(); id_valid = 1; id_rs2 = 5; id_rs2_used = 1;
    step(); chk("lu_stall", stall_seen, 1);
    step(); chk("lu_release", stall_seen, 0);
    // load to x0 never stalls
    nop(); id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd = 0;
    step();
    nop(); id_valid = 1; id_rs2 = 0; id_rs2_used = 1;
    step(); chk("lu_x0", stall_seen, 0);
    // bank isolation
    nop(); id_valid = 1; id_is_load = 1; id_rd_we = 1;
    id_rd = 5; id_rd_fp = 1;
    step();
    nop(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    step(); chk("bank_int", stall_seen, 0);
    nop(); id_valid = 1; id_is_load = 1; id_rd_we = 1;
    id_rd = 5; id_rd_fp = 1;
    step();
    nop(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1; id_rs1_fp = 1;
    step(); chk("bank_fp", stall_seen, 1);
    nop(); id_valid = 1; id_is_load = 1; id_rd_we = 1;
    id_rd = 0; id_rd_fp = 1;
    step();
    nop(); id_valid = 1; id_rs3 = 0; id_rs3_used = 1; id_rs3_fp = 1;
    step(); chk("lu_f0", stall_seen, 1);
    step();
    // hold during a load-use window
    nop(); id_valid = 1; id_is_load = 1; id_rd_we = 1; id_rd = 7;
    step();
    nop(); id_valid = 1; id_rs1 = 7; id_rs1_used = 1; pipe_hold = 1;
    step(); chk("hold1", stall_seen, 1);
    step(); chk("hold2", stall_seen, 1);
    pipe_hold = 0;
    step(); chk("hold_rel", stall_seen, 1);
    step(); chk("hold_done", stall_seen, 0);

    // multi-cycle RAW, lat 6 to f3
    mc_op(3, 6); t0 = cyc;
    step();
    nop(); id_valid = 1; id_rs1 = 3; id_rs1_used = 1; id_rs1_fp = 1;
    n = 0; dcyc = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_seen) dcyc = cyc - 1;
      if (!stall_seen) break;
      n++;
    end
    chk("mc_raw_len", n, 6);
    chk("mc_done_cyc", dcyc - t0, 6);

    // WAW from an integer-pipe write to a pending FP rd
    mc_op(2, 4); step();
    nop(); id_valid = 1; id_rd_we = 1; id_rd = 2; id_rd_fp = 1;
    run_stalled(n); chk("waw_len", n, 4);

    // latency 0 acts as 1
    mc_op(1, 0); step();
    nop(); step(); chk("lat0_done", done_seen, 1);
    nop(); for (int i = 0; i < 5; i++) step();

    // structural: two long ops busy, third waits for a free slot
    mc_op(8, 10); step();
    mc_op(9, 12); step();
    mc_op(10, 3);
    run_stalled(n); chk("struct_len", n, 9);
    nop(); for (int i = 0; i < 20; i++) step();

    // writeback collision: lat 5 would land on the lat 8 result
    mc_op(11, 8); step();
    nop(); step(); step();
    mc_op(12, 5);
    run_stalled(n); chk("coll_len", n, 1);
    nop(); dn = 0;
    for (int i = 0; i < 12; i++) begin step(); dn += int'(done_seen); end
    chk("coll_dones", dn, 2);

    // asynchronous reset with both slots busy
    mc_op(2, 9); step();
    mc_op(4, 12); step();
    nop(); id_valid = 1; id_rs1 = 2; id_rs1_used = 1; id_rs1_fp = 1;
    step(); chk("pre_rst_stall", stall_seen, 1);
    #2 reset_i = 1;
    #1;
    chk("arst_busy", mc_busy_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_done", mc_done_o, 0);
    ops.delete(); ld_v = 0;
    @(posedge clk_i); #1;
    reset_i = 0; cyc++;
    nop(); dn = 0;
    for (int i = 0; i < 20; i++) begin step(); dn += int'(done_seen); end
    chk("post_rst_dones", dn, 0);

    // random traffic
    for (int it = 0; it < 3000; it++) begin
      nop();
      id_valid = ($urandom % 4) != 0;
      id_rs1 = 5'($urandom % 4); id_rs1_fp = 1'($urandom);
      id_rs2 = 5'($urandom % 4); id_rs2_fp = 1'($urandom);
      id_rs3 = 5'($urandom % 4); id_rs3_fp = 1'($urandom);
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_rs3_used = ($urandom % 4) == 0;
      id_rd = 5'($urandom % 4); id_rd_fp = 1'($urandom);
      id_rd_we = ($urandom % 4) != 0;
      case ($urandom % 4)
        0: id_is_load = 1;
        1: id_is_mc = 1;
        default: ;
      endcase
      id_mc_lat = 5'($urandom % 8);
      pipe_hold = ($urandom % 10) == 0;
      flush = ($urandom % 20) == 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
